toggle_evt_responder: RTL
=========================

Name: toggle_evt_responder

Overview:
- Responder end of the team's two-phase toggle handshake. The initiator side flips a T flip-flop once per event; this block is the receiving end.
- Synchronises the incoming toggle level and decodes each transition into one event.
- Buffers up to PEND_MAX outstanding events behind a valid/ready interface.
- Returns a toggle acknowledge (internal T flip-flop) for every consumed event. Sits at a clock-domain boundary in front of a local consumer.

Parameters:
SYNC_STAGES, 2, synchroniser depth on req_t (legal 2..4)
PEND_MAX, 4, max buffered events (legal 1..15)
CNT_W, 8, width of total event counter
PW, derived = $clog2(PEND_MAX+1), width of pend_cnt

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
req_t  input  1  asynchronous toggle request; each level change = one event
evt_pulse  output  1  one-cycle strobe per detected transition (includes dropped events)
evt_valid  output  1  at least one event pending
evt_ready  input  1  consumer accepts one event when evt_valid high
ack_t  output  1  acknowledge toggle; flips once per consumed event
pend_cnt  output  PW  number of pending events
total_cnt  output  CNT_W  detected transitions, modulo 2^CNT_W
ovf  output  1  sticky: event dropped because buffer full
clr_ovf  input  1  synchronous clear of ovf

Behaviour:
- Reset (rst_n=0, asynchronous): the following all go to 0 immediately:
  - sync chain, req_prev, arm counter
  - evt_pulse, evt_valid, ack_t, pend_cnt, total_cnt, ovf
- Sync: req_t passes through SYNC_STAGES flops; s = last stage.
- Arming:
  - After rst_n deasserts, the arm counter runs SYNC_STAGES+1 cycles.
  - While unarmed, req_prev <= s and no events are detected. A req_t held at 1 through reset therefore produces no spurious event.
- Detection:
  - det = armed & (s ^ req_prev); req_prev <= s every cycle.
  - Latency: req_t changes before edge n → evt_pulse high during cycle after edge n+SYNC_STAGES, exactly one cycle wide.
  - Each req_t transition yields exactly one det, provided transitions are ≥ SYNC_STAGES+1 cycles apart (initiator obligation; closer transitions may merge, not checked).
- Consume: cons = evt_valid & evt_ready.
- pend_cnt, updated at the same edge as evt_pulse rises:
  - det & !cons & pend<PEND_MAX: +1
  - !det & cons: −1
  - det & cons: unchanged (also when pend=PEND_MAX)
  - det & !cons & pend=PEND_MAX: unchanged, event dropped, ovf <= 1
- States, derived from pend_cnt:
  - IDLE (0): evt_valid=0
  - PENDING (1..PEND_MAX−1): evt_valid=1
  - FULL (PEND_MAX): evt_valid=1
  - evt_valid is registered and equals (pend_cnt != 0) in the same cycle.
- evt_ready while evt_valid=0: ignored; no underflow, no ack.
- ack_t toggles on the edge ending every cons cycle; it never toggles otherwise.
- total_cnt increments on every det, including dropped events; wraps 2^CNT_W−1 → 0.
- ovf:
  - Set by a drop; cleared by clr_ovf.
  - Set and clear in the same cycle: set wins.
- Reset mid-operation: pending events are discarded and ack_t returns to 0; the initiator must also be reset.

Test Plan:
- Defaults, req_t 0→1 at t0, evt_ready=0 → evt_pulse one cycle at edge t0+2; pend_cnt=1; evt_valid=1; total_cnt=1; ack_t=0.
- Then evt_ready=1 for one cycle → pend_cnt=0, evt_valid=0, ack_t=1. Four more accept cycles with evt_valid=0 → ack_t stays 1.
- Six req_t toggles spaced 4 cycles apart, evt_ready=0 → pend_cnt saturates at 4, total_cnt=6, ovf=1 from the 5th event. clr_ovf pulse → ovf=0.
- pend_cnt=4 with detection and consume in the same cycle → pend_cnt stays 4, ovf stays 0, ack_t toggles, total_cnt +1. Also: ovf set and clr_ovf in the same cycle → ovf=1.
- req_t=1 held through reset release → no evt_pulse, total_cnt=0 after 10 cycles. Then req_t→0 → exactly one event.
- CNT_W=3, nine toggles with evt_ready=1 → total_cnt=1 (wrap); ack_t toggled 9 times, ending at 1. Then assert rst_n=0 mid-run with pend_cnt=2 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/toggle_evt_if.sv
// toggle_evt_if: request, event handshake and status bundle for
// the toggle-handshake responder.
interface toggle_evt_if #(
  parameter int PW    = 3,
  parameter int CNT_W = 8
);
  logic             req_t;
  logic             evt_pulse;
  logic             evt_valid;
  logic             evt_ready;
  logic             ack_t;
  logic [PW-1:0]    pend_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic             ovf;
  logic             clr_ovf;

  modport master (
    output req_t,
    output evt_ready,
    output clr_ovf,
    input  evt_pulse,
    input  evt_valid,
    input  ack_t,
    input  pend_cnt,
    input  total_cnt,
    input  ovf
  );

  modport slave (
    input  req_t,
    input  evt_ready,
    input  clr_ovf,
    output evt_pulse,
    output evt_valid,
    output ack_t,
    output pend_cnt,
    output total_cnt,
    output ovf
  );
endinterface

// File: rtl/toggle_evt_responder.sv
// toggle_evt_responder: receiving end of the two-phase toggle handshake.
// Decodes synchronised req_t edges into buffered valid/ready events.
module toggle_evt_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_MAX    = 4,
  parameter int CNT_W       = 8,
  parameter int PW          = $clog2(PEND_MAX + 1)
) (
  input  logic  clk,
  input  logic  rst_n,
  toggle_evt_if.slave bus
);

  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int AW    = $clog2(ARM_N + 1);

  localparam logic [AW-1:0] ARM_DONE = AW'(ARM_N);
  localparam logic [PW-1:0] PMAX     = PW'(PEND_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_FULL
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_prev_q;
  logic [AW-1:0]          arm_q, arm_d;

  state_e                 state_q, state_d;
  logic [PW-1:0]          pend_q, pend_d;
  logic                   valid_q, valid_d;
  logic                   pulse_q, pulse_d;
  logic                   ack_q, ack_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       total_q, total_d;

  logic s;
  logic armed;
  logic det;
  logic cons;
  logic drop;

  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.req_t};

  // Hold off detection until the chain holds real req_t samples
  assign armed = (arm_q == ARM_DONE);
  assign arm_d = armed ? arm_q : arm_q + AW'(1);

  assign det  = armed & (s ^ req_prev_q);
  assign cons = valid_q & bus.evt_ready;

  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    unique case ({det, cons})
      2'b10: begin
        if (state_q == S_FULL) drop = 1'b1;
        else pend_d = pend_q + PW'(1);
      end
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    state_d = S_PEND;
    unique case (1'b1)
      (pend_d == '0):   state_d = S_IDLE;
      (pend_d == PMAX): state_d = S_FULL;
      default:          state_d = S_PEND;
    endcase
  end

  // Drop beats clear when both land on the same edge
  assign ovf_d   = drop | (ovf_q & ~bus.clr_ovf);
  assign valid_d = (state_d != S_IDLE);
  assign pulse_d = det;
  assign ack_d   = ack_q ^ cons;
  assign total_d = total_q + CNT_W'(det);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      req_prev_q <= 1'b0;
      arm_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      req_prev_q <= s;
      arm_q      <= arm_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      total_q <= total_d;
    end
  end

  assign bus.evt_pulse = pulse_q;
  assign bus.evt_valid = valid_q;
  assign bus.ack_t     = ack_q;
  assign bus.pend_cnt  = pend_q;
  assign bus.total_cnt = total_q;
  assign bus.ovf       = ovf_q;

endmodule
